// File: rtl/snoop_bus_arbiter.sv
// Round-robin snoop bus arbiter with registered broadcast, flush data steering and hit combine.
// Optional tenure limit enabled by defining SNOOP_ARB_TIMEOUT_EN.
module snoop_bus_arbiter #(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned MAX_TENURE = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CORES-1:0]           req_core,
  output logic [NUM_CORES-1:0]           grant,
  input  logic [NUM_CORES*DATA_W-1:0]    core_data_out,
  input  logic [NUM_CORES*ADDR_W-1:0]    core_address_out,
  input  logic [NUM_CORES*2-1:0]         core_operation_out,
  input  logic [NUM_CORES-1:0]           core_cache_hit_out,
  input  logic [NUM_CORES-1:0]           core_flush_out,
  output logic [DATA_W-1:0]              bus_data_in,
  output logic [ADDR_W-1:0]              bus_address_in,
  output logic [1:0]                     bus_operation_in,
  output logic [NUM_CORES-1:0]           cache_hit_in,
  output logic [$clog2(NUM_CORES)-1:0]   owner_id,
  output logic                           bus_busy
);

  localparam int unsigned IdW      = $clog2(NUM_CORES);
  localparam logic [1:0]  OpBusNon = 2'b11;

  typedef enum logic {StIdle, StOwned} state_e;

  state_e               state_q;
  logic [IdW-1:0]       owner_q, rr_ptr_q;
  logic [NUM_CORES-1:0] grant_q, hit_q;
  logic [DATA_W-1:0]    data_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [1:0]           op_q;

  logic [IdW-1:0]       owner_next, idle_pick, hand_pick;
  logic [NUM_CORES-1:0] others;
  logic                 any_req, any_other, owner_req, preempt;
  logic [DATA_W-1:0]    data_d;
  logic [ADDR_W-1:0]    addr_d;
  logic [1:0]           op_d;
  logic [NUM_CORES-1:0] hit_d;

  // First set bit of vec at or after start, wrapping modulo NUM_CORES.
  function automatic logic [IdW-1:0] rr_pick(input logic [NUM_CORES-1:0] vec,
                                             input logic [IdW-1:0] start);
    logic found;
    int   idx;
    rr_pick = start;
    found   = 1'b0;
    for (int k = 0; k < int'(NUM_CORES); k++) begin
      idx = (int'(start) + k) % int'(NUM_CORES);
      if (!found && vec[idx]) begin
        rr_pick = IdW'(idx);
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [NUM_CORES-1:0] to_onehot(input logic [IdW-1:0] idx);
    to_onehot      = '0;
    to_onehot[idx] = 1'b1;
  endfunction

  always_comb begin
    owner_next = (int'(owner_q) == int'(NUM_CORES) - 1) ? '0 : owner_q + IdW'(1);
    others     = req_core & ~grant_q;
    any_req    = |req_core;
    any_other  = |others;
    owner_req  = req_core[owner_q];
    idle_pick  = rr_pick(req_core, rr_ptr_q);
    hand_pick  = rr_pick(others, owner_next);
  end

`ifdef SNOOP_ARB_TIMEOUT_EN
  localparam int unsigned TenW = $clog2(MAX_TENURE);
  logic [TenW-1:0] tenure_q;
  logic            tenure_max;
  assign tenure_max = (tenure_q == TenW'(MAX_TENURE - 1));
  assign preempt    = tenure_max && any_other;
`else
  assign preempt = 1'b0;
`endif

  // Broadcast source: owner's transaction, data overridden by lowest-indexed flushing non-owner.
  always_comb begin
    data_d = '0;
    addr_d = '0;
    op_d   = OpBusNon;
    if (state_q == StOwned) begin
      data_d = core_data_out[int'(owner_q)*DATA_W +: DATA_W];
      addr_d = core_address_out[int'(owner_q)*ADDR_W +: ADDR_W];
      op_d   = core_operation_out[int'(owner_q)*2 +: 2];
      for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
        if (core_flush_out[i] && !grant_q[i]) data_d = core_data_out[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    hit_d = '0;
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      hit_d[i] = |(core_cache_hit_out & ~(NUM_CORES'(1) << i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      data_q   <= '0;
      addr_q   <= '0;
      op_q     <= OpBusNon;
      hit_q    <= '0;
`ifdef SNOOP_ARB_TIMEOUT_EN
      tenure_q <= '0;
`endif
    end else begin
      data_q <= data_d;
      addr_q <= addr_d;
      op_q   <= op_d;
      hit_q  <= hit_d;
      case (state_q)
        StIdle: begin
          if (any_req) begin
            state_q <= StOwned;
            owner_q <= idle_pick;
            grant_q <= to_onehot(idle_pick);
`ifdef SNOOP_ARB_TIMEOUT_EN
            tenure_q <= '0;
`endif
          end
        end
        StOwned: begin
          if (!owner_req || preempt) begin
            rr_ptr_q <= owner_next;
            if (any_other) begin
              owner_q <= hand_pick;
              grant_q <= to_onehot(hand_pick);
`ifdef SNOOP_ARB_TIMEOUT_EN
              tenure_q <= '0;
`endif
            end else begin
              state_q <= StIdle;
              grant_q <= '0;
            end
          end else begin
`ifdef SNOOP_ARB_TIMEOUT_EN
            if (!tenure_max) tenure_q <= tenure_q + TenW'(1);
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant            = grant_q;
  assign owner_id         = owner_q;
  assign bus_busy         = (state_q == StOwned);
  assign bus_data_in      = data_q;
  assign bus_address_in   = addr_q;
  assign bus_operation_in = op_q;
  assign cache_hit_in     = hit_q;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter (4 cores, MAX_TENURE=4).
module tb_snoop_bus_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_core, grant, hit_o, flush_o, cache_hit_in;
  logic [N*DW-1:0] core_data;
  logic [N*AW-1:0] core_addr;
  logic [N*2-1:0]  core_op;
  logic [DW-1:0]   bus_data_in;
  logic [AW-1:0]   bus_address_in;
  logic [1:0]      bus_operation_in;
  logic [1:0]      owner_id;
  logic            bus_busy;

  int checks = 0;
  int errors = 0;

  snoop_bus_arbiter #(
    .NUM_CORES (N),
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .MAX_TENURE(4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req_core          (req_core),
    .grant             (grant),
    .core_data_out     (core_data),
    .core_address_out  (core_addr),
    .core_operation_out(core_op),
    .core_cache_hit_out(hit_o),
    .core_flush_out    (flush_o),
    .bus_data_in       (bus_data_in),
    .bus_address_in    (bus_address_in),
    .bus_operation_in  (bus_operation_in),
    .cache_hit_in      (cache_hit_in),
    .owner_id          (owner_id),
    .bus_busy          (bus_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_core(input int i, input logic [DW-1:0] d, input logic [AW-1:0] a,
                          input logic [1:0] op);
    core_data[i*DW +: DW] = d;
    core_addr[i*AW +: AW] = a;
    core_op[i*2 +: 2]     = op;
  endtask

  logic [N-1:0] rr_seq [4];

  initial begin
    rr_seq[0] = 4'b0010; rr_seq[1] = 4'b0100; rr_seq[2] = 4'b1000; rr_seq[3] = 4'b0001;
    reset = 1'b1; req_core = '0; hit_o = '0; flush_o = '0;
    core_data = '0; core_addr = '0; core_op = '0;
    for (int i = 0; i < N; i++) set_core(i, 32'h1000 + i, 32'h2000 + i, 2'b01);

    // Reset values
    tick(); tick();
    chk("rst_grant", grant, 0);
    chk("rst_busy", bus_busy, 0);
    chk("rst_owner", owner_id, 0);
    chk("rst_op", bus_operation_in, 2'b11);
    chk("rst_data", bus_data_in, 0);
    chk("rst_addr", bus_address_in, 0);
    chk("rst_hit", cache_hit_in, 0);
    reset = 1'b0;
    tick();
    chk("idle_grant", grant, 0);
    chk("idle_op", bus_operation_in, 2'b11);

    // Round-robin with zero-bubble handoff
    req_core = 4'b1111;
    tick();
    chk("rr_first", grant, 4'b0001);
    for (int s = 0; s < 4; s++) begin
      tick();
      tick();
      chk("rr_hold", grant, (s == 0) ? 4'b0001 : rr_seq[s-1]);
      req_core = 4'b1111 & ~grant;
      tick();
      chk("rr_next", grant, rr_seq[s]);
      chk("rr_busy", bus_busy, 1);
      req_core = 4'b1111;
    end
    chk("rr_owner0", owner_id, 0);
    req_core = '0;
    tick();
    chk("rel_grant", grant, 0);
    chk("rel_busy", bus_busy, 0);

    // Broadcast from core 2 (rr_ptr now 1)
    req_core = 4'b0100;
    set_core(2, 32'hA5, 32'h100, 2'b10);
    tick();
    chk("bc_grant", grant, 4'b0100);
    chk("bc_owner", owner_id, 2);
    tick();
    chk("bc_addr", bus_address_in, 32'h100);
    chk("bc_op", bus_operation_in, 2'b10);
    chk("bc_data", bus_data_in, 32'hA5);

    // Handoff to core 1, then flush and hit combine
    req_core = 4'b0010;
    set_core(1, 32'h1111, 32'h40, 2'b00);
    tick();
    chk("fl_grant", grant, 4'b0010);
    set_core(3, 32'hDEAD, 32'h3333, 2'b11);
    flush_o = 4'b1000;
    hit_o   = 4'b1000;
    tick();
    chk("fl_data", bus_data_in, 32'hDEAD);
    chk("fl_addr", bus_address_in, 32'h40);
    chk("fl_op", bus_operation_in, 2'b00);
    chk("hit_3", cache_hit_in, 4'b0111);
    set_core(0, 32'hBEEF, 32'h0, 2'b01);
    flush_o = 4'b1011;
    hit_o   = 4'b0010;
    tick();
    chk("fl_lowest", bus_data_in, 32'hBEEF);
    chk("hit_owner", cache_hit_in, 4'b1101);
    flush_o = 4'b0010;
    hit_o   = '0;
    tick();
    chk("fl_own_ignored", bus_data_in, 32'h1111);
    chk("hit_clear", cache_hit_in, 0);
    flush_o  = '0;
    req_core = '0;
    tick();
    chk("end_grant", grant, 0);
    tick();
    chk("idle_bus_op", bus_operation_in, 2'b11);
    chk("idle_bus_data", bus_data_in, 0);

    // Tenure limit: core 0 holds, core 1 waits
    req_core = 4'b0001;
    tick();
    chk("to_grant0", grant, 4'b0001);
    req_core = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("to_hold", grant, 4'b0001);
    end
    tick();
`ifdef SNOOP_ARB_TIMEOUT_EN
    chk("to_preempt", grant, 4'b0010);
`else
    chk("to_keep", grant, 4'b0001);
`endif
    tick();
`ifdef SNOOP_ARB_TIMEOUT_EN
    chk("to_after", grant, 4'b0010);
`else
    chk("to_after", grant, 4'b0001);
`endif

    // Reset mid-tenure with core 3 owning
    req_core = 4'b1000;
    tick();
    chk("mr_grant3", grant, 4'b1000);
    req_core = 4'b1111;
    reset    = 1'b1;
    tick();
    chk("mr_grant", grant, 0);
    chk("mr_op", bus_operation_in, 2'b11);
    chk("mr_busy", bus_busy, 0);
    reset = 1'b0;
    tick();
    chk("mr_regrant", grant, 4'b0001);
    chk("mr_owner", owner_id, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
